free_list: RTL and testbench

//  Circular FIFO of unallocated physical register IDs. Sits directly upstream of the dispatcher.

---
 rtl/free_list_pkg.sv | 23 ++
 rtl/free_list_compactor.sv | 40 ++++
 rtl/free_list.sv | 157 +++++++++++++++
 tb/tb_free_list.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_types (package)
// Purpose  : Shared types and constants for the rename free list: physical
//            register ID type, free-list pointer type and the architectural
//            register count.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_types;

  localparam int NUM_PR_ENTRIES = 64;
  localparam int NUM_ARCH_REGS  = 32;

  // Free-list depth and pointer width for the default configuration.
  // The pointer carries one extra MSB used as a wrap bit.
  localparam int FL_DEPTH = NUM_PR_ENTRIES - NUM_ARCH_REGS;
  localparam int FL_PTR_W = $clog2(FL_DEPTH) + 1;

  typedef logic [5:0]          preg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

endpackage
`default_nettype wire

// File: rtl/free_list_compactor.sv
`default_nettype none
// ============================================================================
// Module   : free_list_compactor
// Purpose  : Packs the returning push lanes into consecutive slots.
//            A lane is written when it is valid and its PR is not PR0.
//            Each written lane gets its offset from the tail, in lane order,
//            and the total number written is reported.
// Ports    : push_valid[SS] - lane carries a returned PR
//            push_preg[SS]  - returned PR ID
//            we[SS]         - lane is actually written
//            offset[SS]     - write offset from tail (valid when we=1)
//            count          - number of lanes written
// Revision : 1.0 - initial release
// ============================================================================
module free_list_compactor
  import rv32i_types::*;
#(
  parameter int SS    = 2,
  parameter int CNT_W = $clog2(SS + 1)
) (
  input  logic             push_valid [SS],
  input  preg_t            push_preg  [SS],
  output logic             we         [SS],
  output logic [CNT_W-1:0] offset     [SS],
  output logic [CNT_W-1:0] count
);

  // Running prefix sum: each lane's offset is the number of written lanes
  // that precede it.
  always_comb begin
    count = '0;
    for (int i = 0; i < SS; i++) begin
      we[i]     = push_valid[i] && (push_preg[i] != '0);
      offset[i] = count;
      count     = count + CNT_W'(we[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module   : free_list
// Purpose  : Circular FIFO of unallocated physical register IDs.
//            It supplies SS destination PRs per dispatch.
//            Commit returns superseded PRs at the tail.
//            On flush, the head rolls back to the architectural head.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            pop_inst_q        - dispatcher consumes free_rat_rds this cycle
//            free_rat_rds[SS]  - next SS free PRs, [0] oldest
//            free_list_empty   - fewer than SS entries available
//            push_valid[SS]    - commit returns a PR in this lane
//            push_preg[SS]     - PR being returned
//            commit_alloc[SS]  - retiring lane had allocated at dispatch
//            flush             - discard speculative allocations
// Revision : 1.0 - initial release
// ============================================================================
module free_list
  import rv32i_types::*;
#(
  parameter int SS         = 2,
  parameter int PR_ENTRIES = NUM_PR_ENTRIES,
  parameter int ARCH_REGS  = NUM_ARCH_REGS
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  pop_inst_q,
  output preg_t free_rat_rds [SS],
  output logic  free_list_empty,
  input  logic  push_valid   [SS],
  input  preg_t push_preg    [SS],
  input  logic  commit_alloc [SS],
  input  logic  flush
);

  localparam int DEPTH = PR_ENTRIES - ARCH_REGS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(SS + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  preg_t            r_mem [DEPTH];
  ptr_t             r_head;
  ptr_t             r_tail;
  ptr_t             r_arch_head;

  ptr_t             w_count;
  logic             w_empty;
  logic             w_pop;
  ptr_t             w_arch_next;
  logic [CNT_W-1:0] w_alloc_cnt;
  logic [CNT_W-1:0] w_push_cnt;
  logic             w_push_we  [SS];
  logic [CNT_W-1:0] w_push_off [SS];
  logic [IDX_W-1:0] w_wr_idx   [SS];

  // The wrap bit makes tail-head the true occupancy: 0 means empty and
  // DEPTH means full.
  assign w_count         = r_tail - r_head;
  assign w_empty         = (w_count < ptr_t'(SS));
  assign free_list_empty = w_empty;
  assign w_pop           = pop_inst_q & ~w_empty & ~flush;

  always_comb begin
    w_alloc_cnt = '0;
    for (int i = 0; i < SS; i++) begin
      w_alloc_cnt = w_alloc_cnt + CNT_W'(commit_alloc[i]);
    end
  end

  assign w_arch_next = r_arch_head + ptr_t'(w_alloc_cnt);

  free_list_compactor #(
    .SS    (SS),
    .CNT_W (CNT_W)
  ) u_compactor (
    .push_valid (push_valid),
    .push_preg  (push_preg),
    .we         (w_push_we),
    .offset     (w_push_off),
    .count      (w_push_cnt)
  );

  for (genvar i = 0; i < SS; i++) begin : g_lane
    assign free_rat_rds[i] = r_mem[r_head[IDX_W-1:0] + IDX_W'(i)];
    assign w_wr_idx[i]     = r_tail[IDX_W-1:0] + IDX_W'(w_push_off[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_arch_head <= '0;
      r_tail      <= ptr_t'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= preg_t'(ARCH_REGS + i);
      end
    end else begin
      r_arch_head <= w_arch_next;
      // Commits in the flush cycle still count toward the restored head.
      if (flush) begin
        r_head <= w_arch_next;
      end else if (w_pop) begin
        r_head <= r_head + ptr_t'(SS);
      end
      r_tail <= r_tail + ptr_t'(w_push_cnt);
      for (int i = 0; i < SS; i++) begin
        if (w_push_we[i]) begin
          r_mem[w_wr_idx[i]] <= push_preg[i];
        end
      end
    end
  end

`ifndef SYNTHESIS
  logic             w_dup;
  logic [IDX_W-1:0] w_dup_off;

  // Checks whether a returned PR is already free: either another lane in
  // this cycle, or a live entry between head and tail.
  always_comb begin
    w_dup     = 1'b0;
    w_dup_off = '0;
    for (int l = 0; l < SS; l++) begin
      if (w_push_we[l]) begin
        for (int m = l + 1; m < SS; m++) begin
          if (w_push_we[m] && (push_preg[m] == push_preg[l])) begin
            w_dup = 1'b1;
          end
        end
        for (int j = 0; j < DEPTH; j++) begin
          w_dup_off = IDX_W'(j) - r_head[IDX_W-1:0];
          if ((ptr_t'(w_dup_off) < w_count) && (r_mem[j] == push_preg[l])) begin
            w_dup = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // The pop is dropped in hardware; this only flags the protocol slip.
      assert (!(pop_inst_q && w_empty))
        else $warning("free_list: pop_inst_q while empty was ignored");
      assert ((int'(w_count) + int'(w_push_cnt)) <= DEPTH)
        else $error("free_list: push overflow");
      assert (ptr_t'(w_alloc_cnt) <= ptr_t'(r_head - r_arch_head))
        else $error("free_list: arch_head passed head");
      assert (!w_dup)
        else $error("free_list: duplicate PR pushed");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list
// Purpose  : Self-checking bench for free_list.
//            A queue model holds the free IDs in order.
//            A second queue holds the dispatched, uncommitted IDs that a
//            flush returns to the front.
// Revision : 1.0 - initial release
// ============================================================================
module tb_free_list;
  import rv32i_types::*;

  localparam int SS = 2;

  logic  clk = 1'b0;
  logic  rst;
  logic  pop_inst_q;
  preg_t free_rat_rds [SS];
  logic  free_list_empty;
  logic  push_valid   [SS];
  preg_t push_preg    [SS];
  logic  commit_alloc [SS];
  logic  flush;

  int errors = 0;
  int checks = 0;
  int free_q[$];
  int alloc_q[$];
  int e0, e1;

  always #5 clk = ~clk;

  free_list #(
    .SS         (SS),
    .PR_ENTRIES (64),
    .ARCH_REGS  (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pop_inst_q      (pop_inst_q),
    .free_rat_rds    (free_rat_rds),
    .free_list_empty (free_list_empty),
    .push_valid      (push_valid),
    .push_preg       (push_preg),
    .commit_alloc    (commit_alloc),
    .flush           (flush)
  );

  task automatic clear_inputs();
    pop_inst_q      = 1'b0;
    flush           = 1'b0;
    push_valid[0]   = 1'b0;
    push_valid[1]   = 1'b0;
    push_preg[0]    = '0;
    push_preg[1]    = '0;
    commit_alloc[0] = 1'b0;
    commit_alloc[1] = 1'b0;
  endtask

  task automatic model_reset();
    free_q.delete();
    alloc_q.delete();
    for (int i = 32; i < 64; i++) free_q.push_back(i);
  endtask

  // One clock of stimulus; the model is advanced at the edge.
  task automatic step(input logic pop, input logic v0, input int p0,
                      input logic v1, input int p1,
                      input logic c0, input logic c1, input logic fl);
    bit eff_pop;
    int n;
    pop_inst_q      = pop;
    push_valid[0]   = v0;
    push_preg[0]    = 6'(p0);
    push_valid[1]   = v1;
    push_preg[1]    = 6'(p1);
    commit_alloc[0] = c0;
    commit_alloc[1] = c1;
    flush           = fl;
    eff_pop = pop && (free_q.size() >= 2) && !fl;
    @(posedge clk);
    n = int'(c0) + int'(c1);
    repeat (n) void'(alloc_q.pop_front());
    if (fl) begin
      while (alloc_q.size() > 0) free_q.push_front(alloc_q.pop_back());
    end else if (eff_pop) begin
      repeat (2) alloc_q.push_back(free_q.pop_front());
    end
    if (v0 && p0 != 0) free_q.push_back(p0);
    if (v1 && p1 != 0) free_q.push_back(p1);
    #1;
    clear_inputs();
  endtask

  task automatic commit_all();
    while (alloc_q.size() >= 2) step(0, 0, 0, 0, 0, 1, 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (free_rat_rds[0] !== 6'd32) begin errors++; $display("FAIL reset_rd0: got %0d expected 32", free_rat_rds[0]); end
    checks++; if (free_rat_rds[1] !== 6'd33) begin errors++; $display("FAIL reset_rd1: got %0d expected 33", free_rat_rds[1]); end
    checks++; if (free_list_empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %b expected 0", free_list_empty); end
    checks++; if (dut.w_count !== 6'd32) begin errors++; $display("FAIL reset_count: got %0d expected 32", dut.w_count); end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 16; k++) begin
      checks++; if (free_rat_rds[0] !== 6'(32 + 2*k)) begin errors++; $display("FAIL drain_rd0[%0d]: got %0d expected %0d", k, free_rat_rds[0], 32 + 2*k); end
      checks++; if (free_rat_rds[1] !== 6'(33 + 2*k)) begin errors++; $display("FAIL drain_rd1[%0d]: got %0d expected %0d", k, free_rat_rds[1], 33 + 2*k); end
      step(1, 0, 0, 0, 0, 0, 0, 0);
    end
    checks++; if (free_list_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", free_list_empty); end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (dut.r_head !== 6'd32) begin errors++; $display("FAIL empty_pop_head: got %0d expected 32", dut.r_head); end
    checks++; if (dut.w_count !== 6'(free_q.size())) begin errors++; $display("FAIL empty_pop_count: got %0d expected %0d", dut.w_count, free_q.size()); end
    commit_all();
    checks++; if (dut.r_arch_head !== 6'd32) begin errors++; $display("FAIL drain_arch_head: got %0d expected 32", dut.r_arch_head); end
  endtask

  task automatic test_refill();
    step(0, 1, 40, 1, 0, 0, 0, 0);
    checks++; if (dut.w_count !== 6'd1) begin errors++; $display("FAIL refill_count1: got %0d expected 1", dut.w_count); end
    checks++; if (free_list_empty !== 1'b1) begin errors++; $display("FAIL refill_empty1: got %b expected 1", free_list_empty); end
    step(0, 1, 41, 1, 42, 0, 0, 0);
    checks++; if (free_rat_rds[0] !== 6'd40) begin errors++; $display("FAIL refill_rd0: got %0d expected 40", free_rat_rds[0]); end
    checks++; if (free_rat_rds[1] !== 6'd41) begin errors++; $display("FAIL refill_rd1: got %0d expected 41", free_rat_rds[1]); end
    checks++; if (free_list_empty !== 1'b0) begin errors++; $display("FAIL refill_empty2: got %b expected 0", free_list_empty); end
  endtask

  task automatic test_wrap();
    int ids[$];
    ids = '{43, 44};
    for (int v = 47; v < 64; v++) ids.push_back(v);
    for (int v = 32; v < 40; v++) ids.push_back(v);
    for (int k = 0; k < ids.size(); k += 2) begin
      if (k + 1 < ids.size()) step(0, 1, ids[k], 1, ids[k+1], 0, 0, 0);
      else                    step(0, 1, ids[k], 0, 0, 0, 0, 0);
    end
    checks++; if (dut.w_count !== 6'd30) begin errors++; $display("FAIL wrap_fill_count: got %0d expected 30", dut.w_count); end
    checks++; if (free_rat_rds[0] !== 6'd40 || free_rat_rds[1] !== 6'd41) begin errors++; $display("FAIL wrap_pre_rds: got %0d,%0d expected 40,41", free_rat_rds[0], free_rat_rds[1]); end
    step(1, 1, 45, 1, 46, 0, 0, 0);
    checks++; if (dut.w_count !== 6'd30) begin errors++; $display("FAIL wrap_pp_count: got %0d expected 30", dut.w_count); end
    while (free_q.size() >= 2) begin
      e0 = free_q[0];
      e1 = free_q[1];
      checks++; if (free_rat_rds[0] !== 6'(e0) || free_rat_rds[1] !== 6'(e1)) begin errors++; $display("FAIL wrap_drain: got %0d,%0d expected %0d,%0d", free_rat_rds[0], free_rat_rds[1], e0, e1); end
      step(1, 0, 0, 0, 0, 0, 0, 0);
    end
    checks++; if (dut.r_head !== 6'd0 || dut.r_tail !== 6'd0) begin errors++; $display("FAIL wrap_ptrs: got head=%0d tail=%0d expected 0,0", dut.r_head, dut.r_tail); end
    commit_all();
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      e0 = free_q[0];
      e1 = free_q[1];
      checks++; if (free_rat_rds[0] !== 6'(e0) || free_rat_rds[1] !== 6'(e1)) begin errors++; $display("FAIL flush_pop: got %0d,%0d expected %0d,%0d", free_rat_rds[0], free_rat_rds[1], e0, e1); end
      step(1, 0, 0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 1, 1, 0);
    // Pop and a push of PR32 alongside the flush: the pop is dropped, the push lands.
    step(1, 1, 32, 0, 0, 0, 0, 1);
    checks++; if (dut.r_head !== 6'd2) begin errors++; $display("FAIL flush_head: got %0d expected 2", dut.r_head); end
    checks++; if (dut.r_arch_head !== 6'd2) begin errors++; $display("FAIL flush_arch_head: got %0d expected 2", dut.r_arch_head); end
    checks++; if (free_rat_rds[0] !== 6'd34 || free_rat_rds[1] !== 6'd35) begin errors++; $display("FAIL flush_rds: got %0d,%0d expected 34,35", free_rat_rds[0], free_rat_rds[1]); end
    checks++; if (dut.w_count !== 6'(free_q.size())) begin errors++; $display("FAIL flush_count: got %0d expected %0d", dut.w_count, free_q.size()); end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (free_rat_rds[0] !== 6'(free_q[0]) || free_rat_rds[1] !== 6'(free_q[1])) begin errors++; $display("FAIL flush_next_rds: got %0d,%0d expected %0d,%0d", free_rat_rds[0], free_rat_rds[1], free_q[0], free_q[1]); end
  endtask

  task automatic test_reset_mid();
    rst             = 1'b1;
    pop_inst_q      = 1'b1;
    push_valid[0]   = 1'b1;
    push_preg[0]    = 6'd34;
    push_valid[1]   = 1'b1;
    push_preg[1]    = 6'd35;
    commit_alloc[0] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    model_reset();
    checks++; if (free_rat_rds[0] !== 6'd32 || free_rat_rds[1] !== 6'd33) begin errors++; $display("FAIL rstmid_rds: got %0d,%0d expected 32,33", free_rat_rds[0], free_rat_rds[1]); end
    checks++; if (free_list_empty !== 1'b0) begin errors++; $display("FAIL rstmid_empty: got %b expected 0", free_list_empty); end
    checks++; if (dut.r_head !== 6'd0 || dut.r_arch_head !== 6'd0 || dut.r_tail !== 6'd32) begin errors++; $display("FAIL rstmid_ptrs: got %0d,%0d,%0d expected 0,0,32", dut.r_head, dut.r_arch_head, dut.r_tail); end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (free_rat_rds[0] !== 6'd34 || free_rat_rds[1] !== 6'd35) begin errors++; $display("FAIL rstmid_next: got %0d,%0d expected 34,35", free_rat_rds[0], free_rat_rds[1]); end
    checks++; if (dut.w_count !== 6'd30) begin errors++; $display("FAIL rstmid_count: got %0d expected 30", dut.w_count); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_refill();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
